array_7_port_ctrl: RTL and testbench

ARRAY_7_PORT_CTRL -- requirements
Module: array_7_port_ctrl

---
 rtl/array7_pkg.sv | 12 +
 rtl/array7_rsp_fifo.sv | 46 ++++
 rtl/array_7_port_ctrl.sv | 83 ++++++++
 tb/tb_array_7_port_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/array7_pkg.sv
// rtl/array7_pkg.sv - shared widths and response entry type for the array_7 port controller
package array7_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 24;
  localparam int LANES  = 2;
  localparam int LANE_W = 12;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              write;
  } rsp_entry_t;
endpackage

// File: rtl/array7_rsp_fifo.sv
// rtl/array7_rsp_fifo.sv - 2-entry in-order response queue of {rdata, write}
module array7_rsp_fifo
  import array7_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_push,
  input  rsp_entry_t i_push_data,
  input  logic       i_pop,
  output logic [1:0] o_count,
  output rsp_entry_t o_head
);
  rsp_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  // Guards keep the pointers coherent even if a caller misbehaves.
  assign w_push = i_push & (r_count != 2'd2);
  assign w_pop  = i_pop & (r_count != 2'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/array_7_port_ctrl.sv
// rtl/array_7_port_ctrl.sv - request/response front end for a 16x24 two-lane masked single-port array
// Optional write acknowledgements: ARRAY7_CTRL_WRITE_ACK_EN.
module array_7_port_ctrl
  import array7_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LANES-1:0]  req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANES-1:0]  mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic       r_inflight;
  logic [1:0] w_count;
  logic       w_fire;
  logic       w_rsp_fire;
  logic       w_pop;
  rsp_entry_t w_push_data;
  rsp_entry_t w_head;

  // Credits count queued plus in-flight responses; a pop this cycle is not
  // credited until the next, so streaming reads settle at two per three cycles.
  assign req_ready = ({1'b0, w_count} + {2'b00, r_inflight}) < 3'd2;
  assign w_fire    = req_valid & req_ready & reset_n;

`ifdef ARRAY7_CTRL_WRITE_ACK_EN
  logic r_inflight_write;

  assign w_rsp_fire = w_fire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_inflight_write <= 1'b0;
    else          r_inflight_write <= req_write;
  end

  assign w_push_data.rdata = r_inflight_write ? '0 : mem_rdata;
  assign w_push_data.write = r_inflight_write;
`else
  assign w_rsp_fire        = w_fire & ~req_write;
  assign w_push_data.rdata = mem_rdata;
  assign w_push_data.write = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_inflight <= 1'b0;
    else          r_inflight <= w_rsp_fire;
  end

  // An all-lanes-off write is a no-op for the array, so it is never enabled.
  assign mem_en    = w_fire & ~(req_write & (req_wmask == '0));
  assign mem_wmode = req_write;
  assign mem_addr  = req_addr;
  assign mem_wmask = req_wmask;
  assign mem_wdata = req_wdata;

  assign w_pop = rsp_valid & rsp_ready;

  array7_rsp_fifo u_rsp_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign rsp_valid = (w_count != 2'd0);
  assign rsp_rdata = w_head.rdata;
  assign rsp_write = w_head.write;
endmodule

// File: tb/tb_array_7_port_ctrl.sv
// tb/tb_array_7_port_ctrl.sv - directed table, reset sequence and random run against a queue-based model
module tb_array_7_port_ctrl;
  import array7_pkg::*;

`ifdef ARRAY7_CTRL_WRITE_ACK_EN
  localparam logic ACK = 1'b1;
`else
  localparam logic ACK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_addr;
  logic [1:0]  req_wmask;
  logic [23:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [23:0] rsp_rdata;
  logic        mem_en, mem_wmode;
  logic [3:0]  mem_addr;
  logic [1:0]  mem_wmask;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;

  always #5 clock = ~clock;

  array_7_port_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_write(rsp_write),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // The physical array: read-first, registered read data, lane-masked writes.
  logic [23:0] bmem [16];
  always @(posedge clock) begin
    if (mem_en) begin
      if (!mem_wmode) mem_rdata <= bmem[mem_addr];
      else begin
        if (mem_wmask[0]) bmem[mem_addr][11:0]  <= mem_wdata[11:0];
        if (mem_wmask[1]) bmem[mem_addr][23:12] <= mem_wdata[23:12];
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: outstanding responses in order, each tagged with its fire cycle.
  typedef struct { logic [23:0] rdata; logic write; int cyc; } exp_t;
  exp_t        q[$];
  logic [23:0] model_mem [16];
  int          t = 0;

  function automatic logic m_valid();
    return (q.size() > 0) && (q[0].cyc <= t - 2);
  endfunction

  task automatic model_compare();
    logic fire, en;
    fire = req_valid && (q.size() < 2);
    en   = fire && !(req_write && (req_wmask == 2'b00));
    chk("req_ready", 32'(req_ready), 32'(q.size() < 2));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid()));
    if (m_valid()) begin
      chk("rsp_rdata", 32'(rsp_rdata), 32'(q[0].rdata));
      chk("rsp_write", 32'(rsp_write), 32'(q[0].write));
    end
    chk("mem_en", 32'(mem_en), 32'(en));
    if (en) begin
      chk("mem_wmode", 32'(mem_wmode), 32'(req_write));
      chk("mem_addr", 32'(mem_addr), 32'(req_addr));
      chk("mem_wmask", 32'(mem_wmask), 32'(req_wmask));
      chk("mem_wdata", 32'(mem_wdata), 32'(req_wdata));
    end
  endtask

  task automatic model_update();
    logic fire, pop;
    exp_t e;
    fire = req_valid && (q.size() < 2);
    pop  = m_valid() && rsp_ready;
    if (pop) void'(q.pop_front());
    if (fire && (!req_write || ACK)) begin
      e.rdata = req_write ? 24'h0 : model_mem[req_addr];
      e.write = req_write;
      e.cyc   = t;
      q.push_back(e);
    end
    if (fire && req_write) begin
      if (req_wmask[0]) model_mem[req_addr][11:0]  = req_wdata[11:0];
      if (req_wmask[1]) model_mem[req_addr][23:12] = req_wdata[23:12];
    end
    t++;
  endtask

  task automatic drive(input logic v, input logic w, input logic [3:0] a,
                       input logic [1:0] m, input logic [23:0] d, input logic rr);
    req_valid = v; req_write = w; req_addr = a; req_wmask = m; req_wdata = d; rsp_ready = rr;
  endtask

  typedef struct {
    logic v, w; logic [3:0] a; logic [1:0] m; logic [23:0] d; logic rr;
    logic e_ready, e_en, e_valid; logic [23:0] e_rdata; logic e_write;
  } vec_t;

  function automatic vec_t mk(logic v, logic w, logic [3:0] a, logic [1:0] m, logic [23:0] d,
                              logic rr, logic er, logic een, logic ev, logic [23:0] erd, logic ew);
    vec_t r;
    r.v = v; r.w = w; r.a = a; r.m = m; r.d = d; r.rr = rr;
    r.e_ready = er; r.e_en = een; r.e_valid = ev; r.e_rdata = erd; r.e_write = ew;
    return r;
  endfunction

  vec_t tbl [25];

  initial begin
    tbl[0]  = mk(1, 0, 3, 2'b00, 24'h0,      1, 1,    1, 0,   24'h0,      0);
    tbl[1]  = mk(0, 0, 0, 2'b00, 24'h0,      1, 1,    0, 0,   24'h0,      0);
    tbl[2]  = mk(0, 0, 0, 2'b00, 24'h0,      1, 1,    0, 1,   24'hABC123, 0);
    tbl[3]  = mk(1, 1, 5, 2'b01, 24'hFFFFFF, 1, 1,    1, 0,   24'h0,      0);
    tbl[4]  = mk(0, 0, 0, 2'b00, 24'h0,      1, 1,    0, 0,   24'h0,      0);
    tbl[5]  = mk(1, 0, 5, 2'b00, 24'h0,      1, 1,    1, ACK, 24'h0,      ACK);
    tbl[6]  = mk(0, 0, 0, 2'b00, 24'h0,      1, 1,    0, 0,   24'h0,      0);
    tbl[7]  = mk(1, 0, 7, 2'b00, 24'h0,      1, 1,    1, 1,   24'h123FFF, 0);
    tbl[8]  = mk(1, 1, 7, 2'b11, 24'h222222, 1, 1,    1, 0,   24'h0,      0);
    tbl[9]  = mk(0, 0, 0, 2'b00, 24'h0,      1, !ACK, 0, 1,   24'h000111, 0);
    tbl[10] = mk(0, 0, 0, 2'b00, 24'h0,      1, 1,    0, ACK, 24'h0,      ACK);
    tbl[11] = mk(0, 0, 0, 2'b00, 24'h0,      1, 1,    0, 0,   24'h0,      0);
    tbl[12] = mk(1, 0, 3, 2'b00, 24'h0,      0, 1,    1, 0,   24'h0,      0);
    tbl[13] = mk(1, 0, 5, 2'b00, 24'h0,      0, 1,    1, 0,   24'h0,      0);
    tbl[14] = mk(1, 0, 7, 2'b00, 24'h0,      0, 0,    0, 1,   24'hABC123, 0);
    tbl[15] = mk(1, 0, 7, 2'b00, 24'h0,      0, 0,    0, 1,   24'hABC123, 0);
    tbl[16] = mk(1, 0, 7, 2'b00, 24'h0,      1, 0,    0, 1,   24'hABC123, 0);
    tbl[17] = mk(1, 0, 7, 2'b00, 24'h0,      0, 1,    1, 1,   24'h123FFF, 0);
    tbl[18] = mk(0, 0, 0, 2'b00, 24'h0,      1, 0,    0, 1,   24'h123FFF, 0);
    tbl[19] = mk(0, 0, 0, 2'b00, 24'h0,      1, 1,    0, 1,   24'h222222, 0);
    tbl[20] = mk(0, 0, 0, 2'b00, 24'h0,      1, 1,    0, 0,   24'h0,      0);
    tbl[21] = mk(1, 1, 2, 2'b00, 24'h555555, 1, 1,    0, 0,   24'h0,      0);
    tbl[22] = mk(0, 0, 0, 2'b00, 24'h0,      1, 1,    0, 0,   24'h0,      0);
    tbl[23] = mk(0, 0, 0, 2'b00, 24'h0,      1, 1,    0, ACK, 24'h0,      ACK);
    tbl[24] = mk(0, 0, 0, 2'b00, 24'h0,      1, 1,    0, 0,   24'h0,      0);

    for (int i = 0; i < 16; i++) begin
      bmem[i]      = 24'(i * 24'h010101);
      model_mem[i] = 24'(i * 24'h010101);
    end
    bmem[3] = 24'hABC123; model_mem[3] = 24'hABC123;
    bmem[5] = 24'h123456; model_mem[5] = 24'h123456;
    bmem[7] = 24'h000111; model_mem[7] = 24'h000111;

    // Reset state, with a request offered to prove nothing is enabled.
    reset_n = 1'b0;
    drive(1, 0, 3, 2'b11, 24'h0, 1);
    #3;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    drive(0, 0, 0, 2'b00, 24'h0, 1);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(posedge clock); #1;
      drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].m, tbl[i].d, tbl[i].rr);
      @(negedge clock);
      chk($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_mem_en", i), 32'(mem_en), 32'(tbl[i].e_en));
      chk($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_en) chk($sformatf("tbl%0d_mem_wmode", i), 32'(mem_wmode), 32'(tbl[i].w));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(tbl[i].e_rdata));
        chk($sformatf("tbl%0d_rsp_write", i), 32'(rsp_write), 32'(tbl[i].e_write));
      end
      model_update();
    end

    // Reset in the cycle after a read fire discards the in-flight read.
    @(posedge clock); #1;
    drive(1, 0, 3, 2'b00, 24'h0, 1);
    @(negedge clock);
    model_compare();
    model_update();
    @(posedge clock); #1;
    reset_n = 1'b0;
    drive(1, 0, 5, 2'b00, 24'h0, 1);
    #1;
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
    @(posedge clock);
    @(negedge clock);
    drive(0, 0, 0, 2'b00, 24'h0, 1);
    reset_n = 1'b1;
    q.delete();
    t += 4;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      drive(0, 0, 0, 2'b00, 24'h0, 1);
      @(negedge clock);
      chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      model_compare();
      model_update();
    end

    // Random traffic, with phases of heavy and light response back-pressure.
    for (int i = 0; i < 1500; i++) begin
      int rr_pct;
      rr_pct = ((i / 100) % 3 == 0) ? 20 : 80;
      @(posedge clock); #1;
      drive($urandom_range(0, 99) < 65, 1'($urandom), 4'($urandom), 2'($urandom),
            24'($urandom), $urandom_range(0, 99) < rr_pct);
      @(negedge clock);
      model_compare();
      model_update();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
